// File: rtl/extend_pkg.sv
// Shared widths and extension-mode encoding for the immediate extender.
package extend_pkg;

  localparam int DATA_W = 16;
  localparam int IMM5_W = 5;

  typedef enum logic {
    ZERO = 1'b0,
    SIGN = 1'b1
  } sign_mode_e;

endpackage : extend_pkg

// File: rtl/ext_core.sv
// Combinational immediate extender: widens IN_W bits to OUT_W bits by sign or zero fill.
module ext_core
  import extend_pkg::*;
#(
  parameter int IN_W  = IMM5_W,
  parameter int OUT_W = DATA_W
) (
  input  logic             sign,
  input  logic [IN_W-1:0]  In,
  output logic [OUT_W-1:0] Out
);

  generate
    if (IN_W == OUT_W) begin : g_passthru
      // No fill bits exist at equal widths, so the mode input has no effect.
      logic unused_sign;
      assign unused_sign = sign;
      assign Out = In;
    end else begin : g_extend
      logic fill_bit;
      assign fill_bit = (sign_mode_e'(sign) == SIGN) ? In[IN_W-1] : 1'b0;
      assign Out = {{(OUT_W - IN_W){fill_bit}}, In};
    end
  endgenerate

endmodule : ext_core

// File: rtl/extend_5_16.sv
// Immediate extender for the ALU B-operand path with an optional enabled register copy.
module extend_5_16
  import extend_pkg::*;
#(
  parameter int IN_W  = IMM5_W,
  parameter int OUT_W = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sign,
  input  logic [IN_W-1:0]  In,
  input  logic             en,
  output logic [OUT_W-1:0] Out,
  output logic [OUT_W-1:0] Out_q,
  output logic             Out_q_vld
);

  logic [OUT_W-1:0] data_d, data_q;
  logic             vld_d, vld_q;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext_core (
    .sign (sign),
    .In   (In),
    .Out  (Out)
  );

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (en) begin
      data_d = Out;
      vld_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign Out_q     = data_q;
  assign Out_q_vld = vld_q;

endmodule : extend_5_16

// File: tb/tb_extend_5_16.sv
// Directed self-checking bench for extend_5_16: combinational extension and register stage.
module tb_extend_5_16;

  logic        clk;
  logic        rst_n;
  logic        sign;
  logic [4:0]  in_imm;
  logic        en;
  logic [15:0] out_c;
  logic [15:0] out_q;
  logic        out_q_vld;

  int checks;
  int errors;

  extend_5_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sign      (sign),
    .In        (in_imm),
    .en        (en),
    .Out       (out_c),
    .Out_q     (out_q),
    .Out_q_vld (out_q_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 16'h%04h, expected 16'h%04h", tag, observed, expected);
    end
  endtask

  typedef struct {
    logic        s;
    logic [4:0]  v;
    logic [15:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$] = '{
    '{1'b0, 5'h00, 16'h0000, "zext_zero"},
    '{1'b1, 5'h0F, 16'h000F, "sext_pos_max"},
    '{1'b1, 5'h10, 16'hFFF0, "sext_neg_min"},
    '{1'b0, 5'h1F, 16'h001F, "zext_all_ones"},
    '{1'b1, 5'h1F, 16'hFFFF, "sext_all_ones"},
    '{1'b1, 5'h00, 16'h0000, "sext_zero"},
    '{1'b0, 5'h15, 16'h0015, "zext_0x15"},
    '{1'b1, 5'h15, 16'hFFF5, "sext_0x15"},
    '{1'b1, 5'h0A, 16'h000A, "sext_0x0a"}
  };

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    sign   = 1'b0;
    in_imm = 5'h00;
    en     = 1'b0;

    // Async reset with no clock edge in between.
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_q", out_q, 16'h0000);
    check("rst_vld", {15'd0, out_q_vld}, 16'h0000);

    // Combinational path, exercised while reset is held.
    foreach (vecs[i]) begin
      sign   = vecs[i].s;
      in_imm = vecs[i].v;
      #1;
      check(vecs[i].tag, out_c, vecs[i].exp);
    end

    // Enable during reset must not load.
    en = 1'b1;
    @(posedge clk); #1;
    check("rst_hold_out_q", out_q, 16'h0000);
    check("rst_hold_vld", {15'd0, out_q_vld}, 16'h0000);

    // Release reset away from the edge, then load FFF0.
    @(negedge clk);
    rst_n  = 1'b1;
    sign   = 1'b1;
    in_imm = 5'h10;
    en     = 1'b1;
    @(posedge clk); #1;
    check("load_out_q", out_q, 16'hFFF0);
    check("load_vld", {15'd0, out_q_vld}, 16'h0001);

    // Hold with en=0 while the combinational output follows In.
    en     = 1'b0;
    in_imm = 5'h01;
    #1;
    check("hold_out_c", out_c, 16'h0001);
    @(posedge clk); #1;
    check("hold_out_q", out_q, 16'hFFF0);
    check("hold_vld", {15'd0, out_q_vld}, 16'h0001);

    // Zero-extended load, then mid-cycle input change must not reach Out_q.
    sign   = 1'b0;
    in_imm = 5'h1F;
    en     = 1'b1;
    @(posedge clk); #1;
    check("load_zext_out_q", out_q, 16'h001F);
    sign   = 1'b1;
    #1;
    check("midcycle_out_c", out_c, 16'hFFFF);
    check("midcycle_out_q", out_q, 16'h001F);

    // Reload FFF0, then drop reset between edges.
    in_imm = 5'h10;
    @(posedge clk); #1;
    en = 1'b0;
    check("reload_out_q", out_q, 16'hFFF0);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_out_q", out_q, 16'h0000);
    check("midrun_rst_vld", {15'd0, out_q_vld}, 16'h0000);
    check("midrun_rst_out_c", out_c, 16'hFFF0);
    in_imm = 5'h07;
    #1;
    check("rst_track_out_c", out_c, 16'h0007);

    #10;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_extend_5_16

// File: doc/extend_5_16.md
# extend_5_16

Combinational 5-bit to 16-bit immediate extender for the unpipelined datapath, with an optional registered copy of the result. Sits between instruction decode and the ALU B-operand mux. It widens 5-bit immediate fields to the 16-bit datapath width as either sign-extended or zero-extended values, under control of `sign`.

## Interface
- `IN_W`, default 5: immediate input width. Must be at least 1 and at most `OUT_W`.
- `OUT_W`, default 16: datapath output width.
- `clk` input 1: clock. Used only by the registered copy.
- `rst_n` input 1: reset for the registered copy. Asynchronous, active-low.
- `sign` input 1: 1 selects sign-extension, 0 selects zero-extension.
- `In` input `IN_W`: immediate field.
- `en` input 1: load enable for the registered copy.
- `Out` output `OUT_W`: combinational extended value.
- `Out_q` output `OUT_W`: registered extended value.
- `Out_q_vld` output 1: `Out_q` holds a value loaded since the last reset.

## Operation
- `Out[IN_W-1:0]` = `In` in all cases.
- When `sign`=1: `Out[OUT_W-1:IN_W]` are all copies of `In[IN_W-1]`.
- When `sign`=0: `Out[OUT_W-1:IN_W]` are all 0.
- When `IN_W` == `OUT_W`: `Out` = `In` and `sign` is ignored.
- `Out` is a pure function of `sign` and `In`. It does not depend on `clk`, `rst_n` or `en`, and is valid while reset is asserted.
- No X-propagation masking. An X on `In` or `sign` may produce X on `Out`.
- Registered copy:
  - On a rising `clk` edge with `en`=1, `Out_q` <= `Out` and `Out_q_vld` <= 1.
  - With `en`=0, `Out_q` and `Out_q_vld` hold their values.

## Timing
- `Out`: zero cycles, combinational. It settles within one combinational delay of any change to `In` or `sign`.
- `Out_q`: one-cycle latency. It reflects the `In`/`sign` values sampled at the rising edge where `en`=1.
- Reset values: `Out_q` = 0 and `Out_q_vld` = 0.
  - Both are applied asynchronously when `rst_n` falls, regardless of `clk`.
  - Both hold while `rst_n`=0, even if `en`=1.
  - Reset deassertion is synchronised externally. The first load occurs at the first rising edge after `rst_n`=1 with `en`=1.
- Reset asserted mid-operation: `Out_q` clears immediately. `Out` keeps tracking its inputs.
- `sign` or `In` toggling between edges affects `Out` only. `Out_q` samples only at the edge.

## Structure
- Shared package `extend_pkg` holds:
  - `DATA_W` = 16 and `IMM5_W` = 5 constants.
  - A `sign_mode_e` enum: ZERO=0, SIGN=1.
- Natural sub-module: `ext_core`, the combinational extender parameterised by `IN_W`/`OUT_W`.
- The top-level adds the `Out_q`/`Out_q_vld` register stage around `ext_core`.
- No other state and no FSM.

## Test plan
- Zero-extend zero: `sign`=0, `In`=5'h00 -> `Out`=16'h0000.
- Sign-extend positive maximum: `sign`=1, `In`=5'h0F -> `Out`=16'h000F.
- Sign-extend negative minimum: `sign`=1, `In`=5'h10 -> `Out`=16'hFFF0.
- Mode toggle on all-ones input:
  - `sign`=0, `In`=5'h1F -> `Out`=16'h001F.
  - Then `sign`=1 with no change to `In` -> `Out`=16'hFFFF.
- Register path:
  - Assert `rst_n`=0 -> `Out_q`=16'h0000 and `Out_q_vld`=0 immediately, with no clock required.
  - Release reset, then `sign`=1, `In`=5'h10, `en`=1 -> after one rising edge `Out_q`=16'hFFF0 and `Out_q_vld`=1.
  - Then `en`=0 and `In`=5'h01 -> `Out_q` stays 16'hFFF0 while `Out`=16'h0001.
- Asynchronous reset mid-run: with `Out_q`=16'hFFF0, drop `rst_n` between clock edges -> `Out_q`=0 and `Out_q_vld`=0 before the next edge. `Out` is unaffected.
